// File: rtl/s2p_frame_pkg.sv
// Shared definitions for the s2p frame controller: FSM states and counter widths.
package s2p_frame_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BIT_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  function automatic int unsigned nib_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s2p_frame_cnt.sv
// Bit/nibble counter pair for the s2p frame controller.
module s2p_frame_cnt
  import s2p_frame_pkg::*;
#(
  parameter int unsigned NIBBLES   = 2,
  parameter int unsigned NIB_CNT_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [NIB_CNT_W-1:0] nib_cnt,
  output logic                 nibble_done,
  output logic                 last_nibble
);

  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [NIB_CNT_W-1:0] nib_cnt_q, nib_cnt_d;

  assign nibble_done = (bit_cnt_q == '1);
  assign last_nibble = (nib_cnt_q == NIB_CNT_W'(NIBBLES - 1));
  assign bit_cnt     = bit_cnt_q;
  assign nib_cnt     = nib_cnt_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    nib_cnt_d = nib_cnt_q;
    if (clr) begin
      bit_cnt_d = '0;
      nib_cnt_d = '0;
    end else if (inc) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      if (nibble_done) begin
        nib_cnt_d = last_nibble ? '0 : nib_cnt_q + NIB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      nib_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      nib_cnt_q <= nib_cnt_d;
    end
  end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Frame sequencer for the 4-bit s2p shifter: start detect, nibble assembly,
// stop check and valid/ready output. Optional even parity via S2P_FRAME_PARITY_EN.
module s2p_frame_ctrl
  import s2p_frame_pkg::*;
#(
  parameter int unsigned NIBBLES  = 2,
  parameter logic        IDLE_LVL = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sin,
  input  logic                     enable,
  output logic                     s2p_en,
  input  logic [NIB_W-1:0]         s2p_pout,
  output logic [NIB_W*NIBBLES-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_err,
  output logic                     overrun,
`ifdef S2P_FRAME_PARITY_EN
  output logic                     parity_err,
`endif
  input  logic                     err_clr
);

  localparam int unsigned W         = NIB_W * NIBBLES;
  localparam int unsigned NIB_CNT_W = nib_cnt_w(NIBBLES);

  state_e state_q, state_d;

  logic                 s2p_en_q, s2p_en_d;
  logic [W-1:0]         asm_q, asm_d;
  logic [W-1:0]         out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic                 cnt_clr, cnt_inc;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [NIB_CNT_W-1:0] nib_cnt;
  logic                 nibble_done, last_nibble;

  logic                 stop_ok, word_good, load, ferr_set, ovr_set;
  logic                 par_bad;

  s2p_frame_cnt #(
    .NIBBLES   (NIBBLES),
    .NIB_CNT_W (NIB_CNT_W)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .clr         (cnt_clr),
    .inc         (cnt_inc),
    .bit_cnt     (bit_cnt),
    .nib_cnt     (nib_cnt),
    .nibble_done (nibble_done),
    .last_nibble (last_nibble)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (enable && (sin == ~IDLE_LVL)) state_d = ST_DATA;
      ST_DATA: begin
        if (nibble_done && last_nibble) begin
`ifdef S2P_FRAME_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    s2p_en_d = (state_d == ST_DATA);
    cnt_inc  = (state_q == ST_DATA);
    cnt_clr  = (state_q != ST_DATA);
    stop_ok  = (sin == IDLE_LVL);
    word_good = (state_q == ST_STOP) && stop_ok && !par_bad;
    ferr_set  = (state_q == ST_STOP) && !stop_ok;
    load      = word_good && (!out_valid_q || out_ready);
    ovr_set   = word_good && !load;
  end

`ifdef S2P_FRAME_PARITY_EN
  logic par_q, par_d;
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  logic perr_set;

  always_comb begin
    par_d     = par_q;
    par_bad_d = par_bad_q;
    perr_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        par_d     = 1'b0;
        par_bad_d = 1'b0;
      end
      ST_DATA:   par_d = par_q ^ sin;
      ST_PARITY: begin
        par_bad_d = par_q ^ sin;
        perr_set  = par_q ^ sin;
      end
      default: ;
    endcase
    parity_err_d = perr_set | (parity_err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q        <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign par_bad    = par_bad_q;
  assign parity_err = parity_err_q;
`else
  assign par_bad = 1'b0;
`endif

  // Nibble j is sampled one edge after it completes (bit_cnt back at 0, nib_cnt=j+1);
  // the final nibble is taken in PARITY or, without parity, in STOP via asm_d.
  always_comb begin
    asm_d = asm_q;
    if ((state_q == ST_DATA) && (bit_cnt == '0) && (nib_cnt != '0)) begin
      for (int unsigned i = 0; i < NIBBLES - 1; i++) begin
        if (nib_cnt == NIB_CNT_W'(i + 1)) asm_d[(NIBBLES-1-i)*NIB_W +: NIB_W] = s2p_pout;
      end
    end
`ifdef S2P_FRAME_PARITY_EN
    if (state_q == ST_PARITY) asm_d[NIB_W-1:0] = s2p_pout;
`else
    if (state_q == ST_STOP) asm_d[NIB_W-1:0] = s2p_pout;
`endif
    out_data_d  = load ? asm_d : out_data_q;
    out_valid_d = load | (out_valid_q & ~out_ready);
    frame_err_d = ferr_set | (frame_err_q & ~err_clr);
    overrun_d   = ovr_set | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2p_en_q    <= 1'b0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s2p_en_q    <= s2p_en_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign s2p_en    = s2p_en_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
